// File: rtl/partition_op_issuer.sv
// partition_op_issuer: buffers partition instructions and issues them to the core one at a time
module partition_op_issuer #(
  parameter int REGION_WIDTH   = 64,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [7:0]              instr_op,
  input  logic [7:0]              instr_a,
  input  logic [7:0]              instr_b,
  input  logic [REGION_WIDTH-1:0] instr_region,
  input  logic                    clear_halt,
  output logic [7:0]              op,
  output logic                    op_valid,
  output logic [REGION_WIDTH-1:0] pnew_region,
  output logic [7:0]              psplit_module_id,
  output logic [REGION_WIDTH-1:0] psplit_mask,
  output logic [7:0]              pmerge_m1,
  output logic [7:0]              pmerge_m2,
  input  logic                    op_done,
  input  logic [7:0]              result_module_id,
  output logic                    busy,
  output logic                    halted,
  output logic                    timeout_err,
  output logic [15:0]             retired_count,
  output logic [7:0]              last_result_id
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam int EW = 24 + REGION_WIDTH;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALTED} state_t;
  state_t r_state, w_next;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_op, r_a, r_b, r_last;
  logic [REGION_WIDTH-1:0] r_region;
  logic [15:0] r_retired;
  logic r_timeout_err;
  logic [EW-1:0] w_head;
  logic w_full, w_empty, w_flush, w_push, w_pop, w_issue, w_retire, w_timeout;
  assign w_head      = r_mem[r_rd];
  assign w_full      = r_count == (AW+1)'(FIFO_DEPTH);
  assign w_empty     = r_count == '0;
  assign w_flush     = r_state == HALTED && clear_halt;
  assign w_push      = instr_valid && !w_full && !w_flush;
  assign w_pop       = r_state == IDLE && !w_empty;
  assign w_issue     = w_pop && w_head[EW-1 -: 8] != 8'hFF;
  assign w_retire    = r_state == WAIT && op_done;
  assign w_timeout   = r_state == WAIT && !op_done && r_cnt == CW'(TIMEOUT_CYCLES - 1);
  assign instr_ready = !w_full;
  assign op_valid    = r_state == ISSUE;
  assign busy        = r_state == ISSUE || r_state == WAIT;
  assign halted      = r_state == HALTED;
  assign timeout_err = r_timeout_err;
  assign op               = r_op;
  assign pnew_region      = r_region;
  assign psplit_mask      = r_region;
  assign psplit_module_id = r_a;
  assign pmerge_m1        = r_a;
  assign pmerge_m2        = r_b;
  assign retired_count    = r_retired;
  assign last_result_id   = r_last;
  // next-state: a popped HALT parks the issuer; op_done beats the timeout
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = w_pop ? (w_issue ? ISSUE : HALTED) : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = op_done ? IDLE : (w_timeout ? HALTED : WAIT);
      HALTED:  w_next = clear_halt ? IDLE : HALTED;
    endcase
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  // instruction storage; validity is tracked by the pointers alone
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {instr_op, instr_a, instr_b, instr_region};
  // FIFO pointers and occupancy; clear_halt discards everything queued
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_flush ? '0 : r_wr + AW'(w_push);
      r_rd    <= w_flush ? '0 : r_rd + AW'(w_pop);
      r_count <= w_flush ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  // operands stay put after issue because the core samples them a cycle late
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_region <= '0;
    end else if (w_issue) begin
      {r_op, r_a, r_b, r_region} <= w_head;
    end
  // completion wait counter, retire bookkeeping and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt         <= '0;
      r_retired     <= '0;
      r_last        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_cnt         <= r_state == ISSUE ? '0 : (r_state == WAIT && !op_done ? r_cnt + 1'b1 : r_cnt);
      r_retired     <= w_retire ? r_retired + 16'd1 : r_retired;
      r_last        <= w_retire ? result_module_id : r_last;
      r_timeout_err <= w_timeout ? 1'b1 : (w_flush ? 1'b0 : r_timeout_err);
    end
endmodule

// File: tb/tb_partition_op_issuer.sv
// tb_partition_op_issuer: randomized scoreboard bench with a simple responding core model
module tb_partition_op_issuer;
  localparam int RW = 64;
  typedef struct { logic [7:0] op, a, b; logic [RW-1:0] r; } ins_t;
  logic clk = 0, rst_n = 0, instr_valid = 0, clear_halt = 0, op_done = 0;
  logic [7:0] instr_op = 0, instr_a = 0, instr_b = 0, result_module_id = 0;
  logic [RW-1:0] instr_region = 0;
  logic instr_ready, op_valid, busy, halted, timeout_err;
  logic [7:0] op, psplit_module_id, pmerge_m1, pmerge_m2, last_result_id;
  logic [RW-1:0] pnew_region, psplit_mask;
  logic [15:0] retired_count;
  int n_tests = 0, n_fail = 0;
  ins_t mdl[$];
  ins_t cur;
  int pend = 0, core_delay = 2, n_issued = 0;
  logic [15:0] exp_retired = 0;
  logic [7:0] exp_last = 0;
  bit chk_ret = 0, prev_valid = 0, prev_halted = 0;

  partition_op_issuer #(.REGION_WIDTH(RW), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_a(instr_a), .instr_b(instr_b), .instr_region(instr_region),
    .clear_halt(clear_halt), .op(op), .op_valid(op_valid), .pnew_region(pnew_region),
    .psplit_module_id(psplit_module_id), .psplit_mask(psplit_mask), .pmerge_m1(pmerge_m1),
    .pmerge_m2(pmerge_m2), .op_done(op_done), .result_module_id(result_module_id),
    .busy(busy), .halted(halted), .timeout_err(timeout_err), .retired_count(retired_count),
    .last_result_id(last_result_id));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  // monitor + core model: checks each issue against the queued instruction, answers after core_delay
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0; chk_ret = 0; prev_valid = 0; prev_halted = 0; op_done = 0;
    end else begin
      if (chk_ret) begin
        chk("retired_count", retired_count, exp_retired);
        chk("last_result_id", last_result_id, exp_last);
        chk("busy_after_retire", busy, 0);
      end
      chk_ret = 0;
      if (prev_valid) chk("op_valid_pulse", op_valid, 0);
      if (halted && !prev_halted && !timeout_err) begin
        if (mdl.size() == 0) fail("halt_without_instr");
        else begin
          chk("halt_src", mdl[0].op, 8'hFF);
          void'(mdl.pop_front());
        end
      end
      op_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chk("hold_op", op, cur.op);
          chk("hold_region", pnew_region, cur.r);
          op_done = 1;
          result_module_id = 8'($urandom);
          exp_retired++;
          exp_last = result_module_id;
          chk_ret = 1;
        end
      end
      if (op_valid) begin
        n_issued++;
        if (mdl.size() == 0) fail("unexpected_issue");
        else begin
          cur = mdl.pop_front();
          chk("op", op, cur.op);
          chk("pnew_region", pnew_region, cur.r);
          chk("psplit_mask", psplit_mask, cur.r);
          chk("psplit_module_id", psplit_module_id, cur.a);
          chk("pmerge_m1", pmerge_m1, cur.a);
          chk("pmerge_m2", pmerge_m2, cur.b);
          if (core_delay > 0) pend = core_delay;
        end
      end
      prev_valid = op_valid;
      prev_halted = halted;
    end
  end

  task automatic push(input logic [7:0] o, input logic [7:0] a, input logic [7:0] b, input logic [RW-1:0] r);
    int t = 0;
    instr_valid = 1; instr_op = o; instr_a = a; instr_b = b; instr_region = r;
    while (!instr_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) fail("push_timeout");
    else mdl.push_back('{op: o, a: a, b: b, r: r});
    @(negedge clk);
    instr_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(mdl.size() == 0 && !busy && pend == 0 && !chk_ret) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) fail("drain_timeout");
    @(negedge clk);
  endtask

  task automatic wait_halted(output int k);
    k = 0;
    while (!halted && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!halted) fail("halt_wait_timeout");
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic release_halt();
    clear_halt = 1;
    instr_valid = 1; instr_op = 8'h00; instr_region = 64'hDEAD;
    mdl.delete();
    @(negedge clk);
    clear_halt = 0; instr_valid = 0;
    chk("clr_halted", halted, 0);
    chk("clr_timeout_err", timeout_err, 0);
    chk("clr_busy", busy, 0);
    chk("clr_ready", instr_ready, 1);
  endtask

  task automatic check_reset_outs(input string nm);
    chk(nm, {op, op_valid, pnew_region, psplit_module_id, psplit_mask, pmerge_m1, pmerge_m2,
             busy, halted, timeout_err, retired_count, last_result_id}, 0);
    chk({nm, "_ready"}, instr_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    int k, n0, e0;
    logic [7:0] ops[5];
    ops = '{8'h00, 8'h01, 8'h02, 8'h05, 8'h00};
    idle(2);
    check_reset_outs("reset");
    rst_n = 1;
    // single PNEW with the standard 3-edge core
    core_delay = 2;
    push(8'h00, 8'h00, 8'h00, 64'h0F);
    drain();
    chk("t1_retired", retired_count, 1);
    chk("t1_busy", busy, 0);
    // five back-to-back pushes into a stalled core fill the FIFO
    core_delay = 6;
    for (int i = 0; i < 5; i++)
      push(ops[i], 8'(i == 1 || i == 2 ? 0 : i), 8'(i == 2 ? 1 : 0), 64'(i == 1 ? 3 : i + 16));
    chk("full_ready", instr_ready, 0);
    drain();
    chk("t2_retired", retired_count, 6);
    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      logic [7:0] o;
      int sel;
      sel = $urandom_range(0, 4);
      o = sel == 0 ? 8'h00 : sel == 1 ? 8'h01 : sel == 2 ? 8'h02 : sel == 3 ? 8'h05 : 8'($urandom_range(3, 254));
      core_delay = $urandom_range(1, 12);
      push(o, 8'($urandom), 8'($urandom), {$urandom, $urandom});
      idle($urandom_range(0, 3));
    end
    drain();
    chk("rand_retired", retired_count, exp_retired);
    // core never answers: timeout after 16 WAIT cycles
    core_delay = 0;
    push(8'h01, 8'h33, 8'h44, 64'h55);
    k = 0;
    while (!op_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    wait_halted(k);
    chk("timeout_latency", k, 17);
    chk("timeout_err", timeout_err, 1);
    chk("timeout_halted", halted, 1);
    n0 = n_issued;
    e0 = exp_retired;
    push(8'h00, 8'h01, 8'h02, 64'h3);
    push(8'h02, 8'h01, 8'h02, 64'h3);
    idle(4);
    chk("halted_no_issue", n_issued, n0);
    chk("halted_ready", instr_ready, 1);
    release_halt();
    idle(4);
    chk("flushed", n_issued, n0);
    chk("keep_retired", retired_count, e0);
    // HALT in the stream
    core_delay = 2;
    push(8'h00, 8'h00, 8'h00, 64'h1);
    push(8'hFF, 8'h00, 8'h00, 64'h0);
    push(8'h00, 8'h00, 8'h00, 64'h2);
    wait_halted(k);
    idle(4);
    chk("halt_issued", n_issued, n0 + 1);
    chk("halt_retired", retired_count, e0 + 1);
    chk("halt_no_timeout", timeout_err, 0);
    release_halt();
    idle(4);
    chk("halt_flushed", n_issued, n0 + 1);
    // op_done on the last allowed WAIT cycle still retires
    e0 = exp_retired;
    core_delay = 16;
    push(8'h02, 8'h07, 8'h09, 64'hA5);
    drain();
    chk("boundary_retired", retired_count, e0 + 1);
    chk("boundary_no_timeout", timeout_err, 0);
    chk("boundary_not_halted", halted, 0);
    // async reset while waiting with entries queued
    core_delay = 0;
    push(8'h00, 8'h01, 8'h01, 64'h10);
    push(8'h01, 8'h02, 8'h02, 64'h20);
    push(8'h02, 8'h03, 8'h03, 64'h30);
    idle(2);
    chk("pre_reset_busy", busy, 1);
    rst_n = 0;
    #1;
    check_reset_outs("mid_reset");
    mdl.delete();
    exp_retired = 0;
    exp_last = 0;
    @(negedge clk);
    rst_n = 1;
    n0 = n_issued;
    idle(5);
    chk("post_reset_quiet", n_issued, n0);
    core_delay = 2;
    push(8'h05, 8'h11, 8'h22, 64'h77);
    drain();
    chk("post_reset_retired", retired_count, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
